// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with writeback bypass and load-use detection.
// Holds on stall, bubbles on flush or a load-use hazard.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic [AW-1:0]     id_rd,
  input  logic [DATA_W-1:0] id_read_data1,
  input  logic [DATA_W-1:0] id_read_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  input  logic              wb_reg_write_en,
  input  logic [AW-1:0]     wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_rd,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [3:0]        ex_alu_op,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_plus4;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [3:0]        alu_op;
  } ex_t;

  ex_t  ex_q;
  ex_t  ex_load;
  logic wb_live;
  logic rs_hit;
  logic rt_hit;

  // Build the incoming bundle; a same-cycle writeback overrides a stale read.
  always_comb begin
    wb_live = wb_reg_write_en && (wb_write_reg != '0);
    rs_hit  = wb_live && (wb_write_reg == id_rs);
    rt_hit  = wb_live && (wb_write_reg == id_rt);
    ex_load            = '0;
    ex_load.valid      = id_valid;
    ex_load.pc_plus4   = id_pc_plus4;
    ex_load.rs         = id_rs;
    ex_load.rt         = id_rt;
    ex_load.rd         = id_rd;
    ex_load.op1        = rs_hit ? wb_write_data : id_read_data1;
    ex_load.op2        = rt_hit ? wb_write_data : id_read_data2;
    ex_load.imm        = id_imm;
    ex_load.reg_write  = id_reg_write;
    ex_load.mem_read   = id_mem_read;
    ex_load.mem_write  = id_mem_write;
    ex_load.mem_to_reg = id_mem_to_reg;
    ex_load.alu_src    = id_alu_src;
    ex_load.reg_dst    = id_reg_dst;
    ex_load.alu_op     = id_alu_op;
  end

  // A load in EX whose target is read by ID forces one bubble.
  always_comb begin
    load_use_stall = ex_q.valid && ex_q.mem_read && id_valid
                  && (ex_q.rt != '0)
                  && ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
  end

  // Register update: reset, flush, hold, hazard bubble, then normal load.
  always_ff @(posedge clk) begin
    priority case (1'b1)
      !rst_n:         ex_q <= '0;
      flush:          ex_q <= '0;
      stall:          ex_q <= ex_q;
      load_use_stall: ex_q <= '0;
      default:        ex_q <= ex_load;
    endcase
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_op1        = ex_q.op1;
  assign ex_op2        = ex_q.op2;
  assign ex_imm        = ex_q.imm;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_op     = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed hazard cases then
// randomized traffic against a register-file level reference model.
module tb_id_ex_reg;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, stall, flush, id_valid;
  logic [DW-1:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]    id_alu_op;
  logic          wb_reg_write_en;
  logic [AW-1:0] wb_write_reg;
  logic [DW-1:0] wb_write_data;

  logic          ex_valid;
  logic [DW-1:0] ex_pc_plus4, ex_op1, ex_op2, ex_imm;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]    ex_alu_op;
  logic          load_use_stall;

  id_ex_reg #(.DATA_W(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .wb_reg_write_en(wb_reg_write_en), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .load_use_stall(load_use_stall)
  );

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] imm;
    logic [5:0]    ctl;
    logic [3:0]    alu_op;
  } st_t;

  typedef struct packed {
    logic chk_lus;
    logic lus;
    st_t  ex;
  } item_t;

  item_t         q[$];
  st_t           m = '0;
  bit            known = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] rf[32];

  // Value the instruction should see for register r: whatever the
  // register file holds once this cycle's writeback lands, except
  // register 0, which always passes the read port through.
  function automatic logic [DW-1:0] operand(
    input logic [AW-1:0] r, input logic [DW-1:0] rd_port);
    if (r == '0) return rd_port;
    if (wb_reg_write_en && wb_write_reg == r) return wb_write_data;
    return rd_port;
  endfunction

  task automatic step();
    item_t it;
    st_t   nx;
    logic  lus;
    lus = m.valid && m.ctl[4] && id_valid && (m.rt != '0)
       && ((m.rt == id_rs) || (m.rt == id_rt));
    it.chk_lus = known;
    it.lus = lus;
    nx = m;
    if (!rst_n) begin
      nx = '0;
      known = 1'b1;
    end else if (flush || (!stall && lus)) begin
      nx = '0;
    end else if (!stall) begin
      nx.valid  = id_valid;
      nx.pc     = id_pc_plus4;
      nx.rs     = id_rs;
      nx.rt     = id_rt;
      nx.rd     = id_rd;
      nx.op1    = operand(id_rs, id_read_data1);
      nx.op2    = operand(id_rt, id_read_data2);
      nx.imm    = id_imm;
      nx.ctl    = {id_reg_write, id_mem_read, id_mem_write,
                   id_mem_to_reg, id_alu_src, id_reg_dst};
      nx.alu_op = id_alu_op;
    end
    it.ex = nx;
    m = nx;
    q.push_back(it);
    if (wb_reg_write_en && wb_write_reg != '0)
      rf[wb_write_reg] = wb_write_data;
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_pc_plus4 = '0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_read_data1 = '0; id_read_data2 = '0; id_imm = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0; id_alu_src = 1'b0; id_reg_dst = 1'b0;
    id_alu_op = '0;
    wb_reg_write_en = 1'b0; wb_write_reg = '0; wb_write_data = '0;
  endtask

  // Monitor: pops one expectation per clock edge and compares.
  initial begin
    item_t it;
    logic  lus_s;
    st_t   got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        lus_s = load_use_stall;
        @(posedge clk);
        #1;
        it = q.pop_front();
        if (it.chk_lus) begin
          n_vec++;
          if (lus_s !== it.lus) begin
            n_err++;
            $display("FAIL load_use_stall: got %b want %b", lus_s, it.lus);
          end
        end
        got = {ex_valid, ex_pc_plus4, ex_rs, ex_rt, ex_rd,
               ex_op1, ex_op2, ex_imm,
               ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_reg_dst, ex_alu_op};
        n_vec++;
        if (got !== it.ex) begin
          n_err++;
          $display("FAIL ex_state @%0t: got %h want %h",
                   $time, got, it.ex);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    step();
    idle();
    step();

    // plain load with negative immediate
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd4;
    id_read_data1 = 32'd42; id_read_data2 = 32'd7;
    id_imm = 32'hFFFF_FFFC; id_pc_plus4 = 32'h104;
    id_reg_write = 1'b1; id_alu_op = 4'd2;
    step();

    // writeback to rs in the same cycle wins over the read port
    wb_reg_write_en = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd99;
    step();
    // register 0 is never bypassed
    id_rs = '0; id_read_data1 = '0; wb_write_reg = '0;
    wb_write_data = 32'd55;
    step();
    idle();

    // load-use: lw rt=3, then add rs=3 stalls once then issues
    id_valid = 1'b1; id_mem_read = 1'b1; id_rt = 5'd3; id_rs = 5'd6;
    step();
    id_mem_read = 1'b0; id_rs = 5'd3; id_rt = 5'd5;
    id_read_data1 = 32'h33; id_read_data2 = 32'h55;
    step();
    step();
    // lw with rt=0 never triggers a hazard
    id_mem_read = 1'b1; id_rt = '0; id_rs = 5'd7;
    step();
    id_mem_read = 1'b0; id_rs = '0; id_rt = '0;
    step();
    idle();

    // stall hold with writebacks to the held rs, then flush+stall
    id_valid = 1'b1; id_rs = 5'd1; id_read_data1 = 32'd5;
    id_reg_write = 1'b1;
    step();
    stall = 1'b1; wb_reg_write_en = 1'b1; wb_write_reg = 5'd1;
    for (int i = 0; i < 3; i++) begin
      wb_write_data = 32'd100 + 32'(i);
      step();
    end
    flush = 1'b1;
    step();
    idle();

    // reset during a stall discards the held instruction
    id_valid = 1'b1; id_mem_read = 1'b1; id_rt = 5'd2; id_rs = 5'd3;
    id_read_data1 = 32'hABCD;
    step();
    stall = 1'b1; rst_n = 1'b0; id_rs = 5'd2; id_mem_read = 1'b0;
    step();
    rst_n = 1'b1; stall = 1'b0;
    step();
    idle();

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 99) >= 2);
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 10);
      id_valid = ($urandom_range(0, 99) < 80);
      id_rs    = AW'($urandom_range(0, 3));
      id_rt    = AW'($urandom_range(0, 3));
      id_rd    = AW'($urandom_range(0, 31));
      id_read_data1 = ($urandom_range(0, 9) == 0) ? $urandom : rf[id_rs];
      id_read_data2 = ($urandom_range(0, 9) == 0) ? $urandom : rf[id_rt];
      id_pc_plus4   = $urandom;
      id_imm        = $urandom;
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 99) < 40);
      id_mem_write  = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_alu_src    = 1'($urandom);
      id_reg_dst    = 1'($urandom);
      id_alu_op     = 4'($urandom);
      wb_reg_write_en = 1'($urandom);
      wb_write_reg    = AW'($urandom_range(0, 3));
      wb_write_data   = $urandom;
      step();
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands, PC and immediate.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  downstream hold; EX registers keep current value.
REQ-006 flush  input  1  branch/jump squash; EX becomes bubble.
REQ-007 id_valid  input  1  ID holds a real instruction.
REQ-008 id_pc_plus4  input  DATA_W  PC+4 of ID instruction.
REQ-009 id_rs, id_rt, id_rd  input  AW each  source/destination register numbers.
REQ-010 id_read_data1, id_read_data2  input  DATA_W  reg_file read ports for rs, rt.
REQ-011 id_imm  input  DATA_W  sign-extended immediate.
REQ-012 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded control.
REQ-013 id_alu_op  input  4  ALU operation code.
REQ-014 wb_reg_write_en, wb_write_reg, wb_write_data  input  1/AW/DATA_W  writeback port, same values driving reg_file.
REQ-015 ex_valid, ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_op1, ex_op2, ex_imm, ex_<control>, ex_alu_op  output  widths as ID counterparts  registered EX-stage copy.
REQ-016 load_use_stall  output  1  combinational; ID/IF must hold this cycle.

Function
REQ-017 Per-edge priority SHALL be: !rst_n > flush > stall > load_use_stall > normal load.
REQ-018 Normal load SHALL capture every id_* field into its ex_* register with 1-cycle latency; ex_valid <= id_valid.
REQ-019 Bubble (flush, or load_use_stall without stall) SHALL set ex_valid, ex_reg_write, ex_mem_read, ex_mem_write to 0; other fields don't-care but SHALL be driven to 0.
REQ-020 stall=1 without flush SHALL hold all ex_* registers unchanged, including ex_valid.
REQ-021 flush and stall both 1 SHALL bubble (flush wins).
REQ-022 Write-through bypass: on load, ex_op1 SHALL take wb_write_data when wb_reg_write_en=1, wb_write_reg!=0 and wb_write_reg==id_rs, else id_read_data1; ex_op2 likewise with id_rt/id_read_data2.
REQ-023 Bypass SHALL never apply for register 0; rs=0 captures id_read_data1 unchanged.
REQ-024 Held (stalled) operands SHALL NOT be updated by later writebacks.
REQ-025 load_use_stall SHALL be 1 iff ex_valid & ex_mem_read & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt); otherwise 0.
REQ-026 load_use_stall SHALL depend only on current ex_* state and id_* inputs (no dependence on stall/flush).
REQ-027 After a load-use bubble, the next edge (ex_mem_read now 0) SHALL load the held ID instruction normally.

Reset
REQ-028 rst_n=0 at an edge SHALL clear every ex_* output to 0 (ex_valid=0, all control 0, data 0), overriding flush/stall.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; load_use_stall SHALL read 0 the cycle after reset.
REQ-030 No state SHALL change without a clk edge; rst_n deassertion takes effect at the next edge.

Verification
REQ-031 Load: id_valid=1, rs=1, rt=2, data1=42, data2=7, imm=-4 -> next edge ex_op1=42, ex_op2=7, ex_imm=0xFFFFFFFC, ex_valid=1.
REQ-032 Bypass: wb writes reg 1 = 99 same cycle ID reads rs=1 (data1=42) -> ex_op1=99; same with wb_write_reg=0, rs=0, data1=0 -> ex_op1=0.
REQ-033 Load-use: EX holds lw rt=3 (mem_read=1), ID add rs=3 -> load_use_stall=1, next edge ex_valid=0, then next edge ex_rs=3, ex_valid=1; with ex_rt=0 -> load_use_stall=0.
REQ-034 Stall hold: load value 5, assert stall 3 cycles while wb writes rs -> ex_op1 stays 5; flush+stall together -> ex_valid=0, ex_reg_write=0.
REQ-035 Reset: rst_n=0 during stall with ex_valid=1 -> next edge all ex_* = 0, load_use_stall=0.
